// File: rtl/fir_pkg.sv
// Shared constants and types for the 16-tap FIR coefficient loader.
package fir_pkg;

   localparam int FIR_NTAPS = 16;
   localparam int FIR_CW    = 16;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      ARMED
   } loader_state_t;

   typedef logic [FIR_CW-1:0] coef_t;

endpackage

// File: rtl/fir_coef_bank.sv
// NTAPS x CW coefficient register bank: indexed single-word write, parallel
// load of the whole bank, flat output with tap 0 in the low slice.
module fir_coef_bank
   import fir_pkg::*;
#(
   parameter int NTAPS = FIR_NTAPS,
   parameter int CW    = FIR_CW,
   localparam int IW   = $clog2(NTAPS)
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [IW-1:0]         wr_idx,
   input  logic [CW-1:0]         wr_data,
   input  logic                  ld_en,
   input  logic [NTAPS*CW-1:0]   ld_data,
   output logic [NTAPS*CW-1:0]   q
);

   logic [CW-1:0] regs [NTAPS];

   // Parallel load has priority; the two write ports are never used together.
   always_ff @(posedge clock) begin
      if (!rst) begin
         for (int i = 0; i < NTAPS; i++) regs[i] <= '0;
      end else if (ld_en) begin
         for (int i = 0; i < NTAPS; i++) regs[i] <= ld_data[i*CW +: CW];
      end else if (wr_en) begin
         regs[wr_idx] <= wr_data;
      end
   end

   always_comb begin
      q = '0;
      for (int i = 0; i < NTAPS; i++) q[i*CW +: CW] = regs[i];
   end

endmodule

// File: rtl/fir_coeff_loader.sv
// Serial coefficient loader: shadow fill over valid/ready, atomic commit to the
// active bank on sample_strobe. Optional checksum with `define FIR_COEF_CKSUM_EN.
module fir_coeff_loader
   import fir_pkg::*;
#(
   parameter int NTAPS = FIR_NTAPS,
   parameter int CW    = FIR_CW
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  load_start,
   input  logic [CW-1:0]         coef_in,
   input  logic                  coef_valid,
   input  logic                  coef_last,
   output logic                  coef_ready,
   input  logic                  sample_strobe,
   output logic [NTAPS*CW-1:0]   h_out,
   output logic                  load_done,
   output logic                  load_err,
   output logic                  busy,
   output logic [CW-1:0]         cksum
);

   localparam int IW = $clog2(NTAPS);
   localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);

   loader_state_t state;
   logic [IW-1:0] idx;
   logic [NTAPS*CW-1:0] shadow_q;
   logic accept;
   logic beat_err;
   logic commit;

   // A restart in LOAD wins over a simultaneous beat, so that beat is dropped.
   assign accept   = (state == LOAD) && coef_valid && !load_start;
   assign beat_err = accept && ((idx == LAST_IDX) != coef_last);
   assign commit   = (state == ARMED) && sample_strobe;

   assign coef_ready = (state == LOAD);
   assign busy       = (state == LOAD) || (state == ARMED);

   always_ff @(posedge clock) begin
      if (!rst) begin
         state     <= IDLE;
         idx       <= '0;
         load_done <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         load_done <= 1'b0;
         load_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (load_start) begin
                  state <= LOAD;
                  idx   <= '0;
               end
            end
            LOAD: begin
               if (load_start) begin
                  idx <= '0;
               end else if (beat_err) begin
                  load_err <= 1'b1;
                  state    <= IDLE;
               end else if (accept) begin
                  if (idx == LAST_IDX) state <= ARMED;
                  else idx <= idx + 1'b1;
               end
            end
            ARMED: begin
               if (commit) begin
                  load_done <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   fir_coef_bank #(.NTAPS(NTAPS), .CW(CW)) u_shadow (
      .clock   (clock),
      .rst     (rst),
      .wr_en   (accept),
      .wr_idx  (idx),
      .wr_data (coef_in),
      .ld_en   (1'b0),
      .ld_data ('0),
      .q       (shadow_q)
   );

   fir_coef_bank #(.NTAPS(NTAPS), .CW(CW)) u_active (
      .clock   (clock),
      .rst     (rst),
      .wr_en   (1'b0),
      .wr_idx  ('0),
      .wr_data ('0),
      .ld_en   (commit),
      .ld_data (shadow_q),
      .q       (h_out)
   );

`ifdef FIR_COEF_CKSUM_EN
   logic [CW-1:0] sum_acc;
   logic [CW-1:0] cksum_q;

   // load_start in ARMED is ignored, so it must not clear the pending sum.
   always_ff @(posedge clock) begin
      if (!rst) begin
         sum_acc <= '0;
         cksum_q <= '0;
      end else begin
         if (load_start && (state != ARMED)) sum_acc <= '0;
         else if (beat_err) sum_acc <= '0;
         else if (accept) sum_acc <= sum_acc + coef_in;
         if (commit) cksum_q <= sum_acc;
      end
   end

   assign cksum = cksum_q;
`else
   assign cksum = '0;
`endif

endmodule
